// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter that gives NREQ requesters shared access to one RAM port pair.
// It accepts one read or write per cycle. Read responses come back one cycle later,
// steered by a one-hot rsp_valid strobe.
module ram_rr_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 128,
  parameter  int NREQ  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  ram_wr_en,
  output logic [AW-1:0]         ram_wr_addr,
  output logic [WIDTH-1:0]      ram_wr_data,
  output logic [AW-1:0]         ram_rd_addr,
  input  logic [WIDTH-1:0]      ram_rd_data
);

  logic [AW-1:0]    addr_arr  [NREQ];
  logic [WIDTH-1:0] wdata_arr [NREQ];

  logic [IW-1:0]    last_gnt_q, last_gnt_d;
  logic [NREQ-1:0]  rsp_pend_q, rsp_pend_d;
  logic [WIDTH-1:0] rsp_data_q;
  logic [AW-1:0]    rd_addr_q;

  logic             gnt_found;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;
  logic             wr_fire;
  logic             rd_fire;
  int               cand;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*AW +: AW];
      assign wdata_arr[gi] = req_wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Search begins one past the last winner and wraps, so a held request waits at most NREQ cycles.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_gnt_q) + k) % NREQ;
      if (!gnt_found && req_valid[IW'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(cand);
      end
    end
  end

  assign gnt_any = gnt_found & ~rst;
  assign wr_fire = gnt_any &  req_we[gnt_idx];
  assign rd_fire = gnt_any & ~req_we[gnt_idx];

  always_comb begin
    req_ready = '0;
    if (gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign ram_wr_en   = wr_fire;
  assign ram_wr_addr = addr_arr[gnt_idx];
  assign ram_wr_data = wdata_arr[gnt_idx];

  // The read address is presented in the grant cycle. It parks on its last value otherwise.
  assign ram_rd_addr = rd_fire ? addr_arr[gnt_idx] : rd_addr_q;

  assign last_gnt_d = gnt_any ? gnt_idx : last_gnt_q;
  assign rsp_pend_d = rd_fire ? req_ready : '0;

  // Masking by rst drops a response whose read was granted just before reset rose.
  assign rsp_valid = rst ? '0 : rsp_pend_q;
  assign rsp_data  = (|rsp_valid) ? ram_rd_data : rsp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= IW'(NREQ - 1);
      rsp_pend_q <= '0;
      rsp_data_q <= '0;
      rd_addr_q  <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rsp_pend_q <= rsp_pend_d;
      rsp_data_q <= rsp_data;
      rd_addr_q  <= ram_rd_addr;
    end
  end

  a_ready_onehot : assert property (@(posedge clk) $onehot0(req_ready));
  a_ready_valid  : assert property (@(posedge clk) (req_ready & ~req_valid) == '0);
  a_rsp_onehot   : assert property (@(posedge clk) $onehot0(rsp_valid));

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: a RAM behind the ports, directed scenarios, then random traffic,
// all checked cycle by cycle against a grant/memory/response reference model.
module tb_ram_rr_arbiter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 128;
  localparam int NREQ  = 4;
  localparam int AW    = $clog2(DEPTH);

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic                  ram_wr_en;
  logic [AW-1:0]         ram_wr_addr;
  logic [WIDTH-1:0]      ram_wr_data;
  logic [AW-1:0]         ram_rd_addr;
  logic [WIDTH-1:0]      ram_rd_data;

  ram_rr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM with a registered read.
  logic [WIDTH-1:0] ram [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= ram[ram_rd_addr];
  end

  // Reference model state
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int               m_last;
  logic             m_pend_v;
  int               m_pend_i;
  logic [WIDTH-1:0] m_pend_d;
  logic [WIDTH-1:0] m_data;
  logic [AW-1:0]    m_rdaddr;

  // Stimulus for the next cycle
  logic                             t_rst;
  logic [NREQ-1:0]                  t_v;
  logic [NREQ-1:0]                  t_we;
  logic [NREQ-1:0][AW-1:0]          t_a;
  logic [NREQ-1:0][WIDTH-1:0]       t_d;

  // Values observed in the most recent cycle
  int               obs_g;
  logic [NREQ-1:0]  obs_ready;
  logic [NREQ-1:0]  obs_rspv;
  logic [WIDTH-1:0] obs_rspd;

  int vec_count = 0;
  int err_count = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    int               g;
    logic             wr_exp;
    logic             rd_exp;
    logic [NREQ-1:0]  er;
    logic [NREQ-1:0]  ev;
    @(negedge clk);
    rst       = t_rst;
    req_valid = t_v;
    req_we    = t_we;
    req_addr  = t_a;
    req_wdata = t_d;
    #1;
    g = -1;
    if (!t_rst) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (g < 0 && t_v[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
      end
    end
    er = '0;
    wr_exp = 1'b0;
    rd_exp = 1'b0;
    if (g >= 0) begin
      er[g]  = 1'b1;
      wr_exp = t_we[g];
      rd_exp = ~t_we[g];
    end
    check("req_ready", req_ready, er);
    check("ram_wr_en", ram_wr_en, wr_exp);
    if (wr_exp) begin
      check("ram_wr_addr", ram_wr_addr, t_a[g]);
      check("ram_wr_data", ram_wr_data, t_d[g]);
    end
    if (rd_exp) m_rdaddr = t_a[g];
    check("ram_rd_addr", ram_rd_addr, m_rdaddr);
    ev = '0;
    if (!t_rst && m_pend_v) begin
      ev[m_pend_i] = 1'b1;
      m_data       = m_pend_d;
    end
    check("rsp_valid", rsp_valid, ev);
    check("rsp_data", rsp_data, m_data);
    obs_g     = g;
    obs_ready = req_ready;
    obs_rspv  = rsp_valid;
    obs_rspd  = rsp_data;
    $display("cyc %0d rst=%0b valid=%b we=%b gnt=%0d rsp_valid=%b rsp_data=%h",
             cyc, t_rst, t_v, t_we, g, rsp_valid, rsp_data);
    @(posedge clk);
    cyc++;
    if (t_rst) begin
      m_last   = NREQ - 1;
      m_pend_v = 1'b0;
      m_data   = '0;
      m_rdaddr = '0;
    end else begin
      m_pend_v = rd_exp;
      if (rd_exp) begin
        m_pend_i = g;
        m_pend_d = ref_mem[t_a[g]];
      end
      if (g >= 0) m_last = g;
      if (wr_exp) ref_mem[t_a[g]] = t_d[g];
    end
  endtask

  task automatic idle_inputs();
    t_rst = 1'b0;
    t_v   = '0;
    t_we  = '0;
    t_a   = '0;
    t_d   = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    m_last = NREQ - 1; m_pend_v = 1'b0; m_pend_i = 0; m_pend_d = '0;
    m_data = '0; m_rdaddr = '0; obs_g = -1;
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    idle_inputs();
    repeat (2) @(posedge clk);

    // Reset state, then all four requesters reading
    t_rst = 1'b1;
    step();
    check("reset_ready", obs_ready, 4'b0000);
    check("reset_rspv", obs_rspv, 4'b0000);
    idle_inputs();
    t_v = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      t_a[i % NREQ] = AW'(i + 20);
      step();
      check("rr_seq_gnt", obs_ready, 4'b0001 << (i % NREQ));
      if (i > 0) check("rr_seq_rsp", obs_rspv, 4'b0001 << ((i - 1) % NREQ));
    end

    // Write by requester 2, then read of the same address by requester 0 on the next cycle
    idle_inputs();
    t_v = 4'b0100; t_we = 4'b0100; t_a[2] = 7'd5; t_d[2] = 8'hA5;
    step();
    check("raw_wr_gnt", obs_ready, 4'b0100);
    idle_inputs();
    t_v = 4'b0001; t_a[0] = 7'd5;
    step();
    idle_inputs();
    step();
    check("raw_rspv", obs_rspv, 4'b0001);
    check("raw_rspd", obs_rspd, 8'hA5);

    // Requester 3 alone: fill addresses 0..4, then stream five reads back-to-back
    idle_inputs();
    t_v = 4'b1000; t_we = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      t_a[3] = AW'(i); t_d[3] = WIDTH'(8'h10 + i);
      step();
    end
    t_we = '0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) t_v = '0;
      t_a[3] = AW'(i);
      step();
      if (i < 5) check("stream_ready", obs_ready, 4'b1000);
      if (i > 0) begin
        check("stream_rspv", obs_rspv, 4'b1000);
        check("stream_rspd", obs_rspd, WIDTH'(8'h10 + i - 1));
      end
    end

    // Wrap-around: last grant 1, then requesters 0 and 1 both valid
    idle_inputs();
    t_v = 4'b0010;
    step();
    t_v = 4'b0011;
    step();
    check("wrap_first", obs_ready, 4'b0001);
    step();
    check("wrap_second", obs_ready, 4'b0010);

    // Reset arrives the cycle after a read grant to requester 1
    idle_inputs();
    t_v = 4'b0010; t_a[1] = 7'd3;
    step();
    check("rstrd_gnt", obs_ready, 4'b0010);
    t_rst = 1'b1; t_v = 4'b0110;
    step();
    check("rstrd_ready", obs_ready, 4'b0000);
    check("rstrd_rspv", obs_rspv, 4'b0000);
    step();
    check("rstrd_ready2", obs_ready, 4'b0000);
    t_rst = 1'b0;
    step();
    check("rstrel_gnt", obs_ready, 4'b0010);
    check("rstrel_rspv", obs_rspv, 4'b0000);

    // Ten idle cycles keep the pointer in place
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_wr_en", ram_wr_en, 1'b0);
    end
    t_v = 4'b1111;
    step();
    check("idle_hold_ptr", obs_ready, 4'b0100);

    // Random traffic. A requester that has not been granted keeps its request stable.
    idle_inputs();
    for (int n = 0; n < 400; n++) begin
      t_rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!t_v[i] || obs_g == i) begin
          t_v[i]  = ($urandom_range(0, 2) != 0);
          t_we[i] = $urandom_range(0, 1) == 1;
          t_a[i]  = AW'($urandom_range(0, 15));
          t_d[i]  = WIDTH'($urandom);
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
